// File: rtl/gpr_word_tx_if.sv
// Handshake and data signals between the control unit and the word transmitter.
// The control unit drives load/B_bus and watches busy/done; tx leaves the chip.
interface gpr_word_tx_if;
   logic        load;
   logic [23:0] B_bus;
   logic        tx;
   logic        busy;
   logic        done;

   modport master (
      output load,
      output B_bus,
      input  tx,
      input  busy,
      input  done
   );

   modport slave (
      input  load,
      input  B_bus,
      output tx,
      output busy,
      output done
   );
endinterface

// File: rtl/gpr_word_tx.sv
// Captures a 24-bit register word from B_bus and shifts it out as three
// back-to-back 8N1 UART frames, low byte first. busy covers the whole word,
// done pulses for one cycle as the final stop bit ends.
module gpr_word_tx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic         clk,
   input  logic         reset,
   gpr_word_tx_if.slave bus
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t           r_state;
   logic [23:0]      r_shift;
   logic [1:0]       r_byte;
   logic [2:0]       r_bit;
   logic [CNT_W-1:0] r_cnt;
   logic             r_tx;
   logic             r_busy;
   logic             r_done;
   logic             w_bit_end;

   // Last cycle of the current bit period
   assign w_bit_end = (r_cnt == CNT_MAX);

   // Frame sequencer: the shift register drops one bit per data bit, so after
   // a byte's eight bits the next byte already sits in r_shift[7:0].
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_shift <= '0;
         r_byte  <= '0;
         r_bit   <= '0;
         r_cnt   <= '0;
         r_tx    <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               r_tx   <= 1'b1;
               r_busy <= 1'b0;
               r_cnt  <= '0;
               if (bus.load) begin
                  r_shift <= bus.B_bus;
                  r_byte  <= '0;
                  r_bit   <= '0;
                  r_tx    <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= START;
               end
            end
            START: begin
               if (w_bit_end) begin
                  r_cnt   <= '0;
                  r_bit   <= '0;
                  r_tx    <= r_shift[0];
                  r_shift <= {1'b0, r_shift[23:1]};
                  r_state <= DATA;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            DATA: begin
               if (w_bit_end) begin
                  r_cnt <= '0;
                  if (r_bit == 3'd7) begin
                     r_tx    <= 1'b1;
                     r_state <= STOP;
                  end else begin
                     r_bit   <= r_bit + 3'd1;
                     r_tx    <= r_shift[0];
                     r_shift <= {1'b0, r_shift[23:1]};
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            STOP: begin
               if (w_bit_end) begin
                  r_cnt <= '0;
                  if (r_byte == 2'd2) begin
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= IDLE;
                  end else begin
                     r_byte  <= r_byte + 2'd1;
                     r_tx    <= 1'b0;
                     r_state <= START;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.tx   = r_tx;
   assign bus.busy = r_busy;
   assign bus.done = r_done;

endmodule

// File: tb/tb_gpr_word_tx.sv
// Bench for gpr_word_tx: two instances (16 and 2 clocks per bit) are checked
// every cycle against a timeline model of the word and by a UART decoder.
module tb_gpr_word_tx;

   localparam int CPB0 = 16;
   localparam int CPB1 = 2;

   logic clk = 1'b0;
   logic rst0;
   logic rst1;
   int   n_chk = 0;
   int   n_err = 0;
   bit   chk_en = 1'b0;

   always #5 clk = ~clk;

   gpr_word_tx_if if0 ();
   gpr_word_tx_if if1 ();

   gpr_word_tx #(.CLKS_PER_BIT(CPB0)) u_dut0 (
      .clk   (clk),
      .reset (rst0),
      .bus   (if0.slave)
   );

   gpr_word_tx #(.CLKS_PER_BIT(CPB1)) u_dut1 (
      .clk   (clk),
      .reset (rst1),
      .bus   (if1.slave)
   );

   logic        rst_v  [2];
   logic        ld_v   [2];
   logic        tx_v   [2];
   logic        busy_v [2];
   logic        done_v [2];
   logic [23:0] bb_v   [2];

   assign rst_v[0]  = rst0;
   assign rst_v[1]  = rst1;
   assign ld_v[0]   = if0.load;
   assign ld_v[1]   = if1.load;
   assign bb_v[0]   = if0.B_bus;
   assign bb_v[1]   = if1.B_bus;
   assign tx_v[0]   = if0.tx;
   assign tx_v[1]   = if1.tx;
   assign busy_v[0] = if0.busy;
   assign busy_v[1] = if1.busy;
   assign done_v[0] = if0.done;
   assign done_v[1] = if1.done;

   // Reference model: a word is a timeline of 30 bit slots starting at acceptance
   bit          m_act  [2];
   int          m_t    [2];
   logic [23:0] m_word [2];
   bit          m_done [2];
   logic [7:0]  q0 [$];
   logic [7:0]  q1 [$];

   // UART decoder state
   bit          mon_on [2];
   int          mon_c  [2];
   logic [7:0]  mon_b  [2];
   int          n_bytes[2];

   function automatic int cpb_of(input int d);
      return (d == 0) ? CPB0 : CPB1;
   endfunction

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] req);
      n_chk++;
      if (obs !== req) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, obs, req, $time);
      end
   endtask

   function automatic logic exp_tx(input int d);
      int k, f, p;
      if (!m_act[d]) return 1'b1;
      k = m_t[d] / cpb_of(d);
      f = k / 10;
      p = k % 10;
      if (p == 0) return 1'b0;
      if (p == 9) return 1'b1;
      return m_word[d][f*8 + p - 1];
   endfunction

   task automatic model_edge(input int d);
      m_done[d] = 1'b0;
      if (rst_v[d]) begin
         m_act[d] = 1'b0;
         if (d == 0) q0.delete(); else q1.delete();
      end else if (m_act[d]) begin
         m_t[d]++;
         if (m_t[d] == 30 * cpb_of(d)) begin
            m_act[d]  = 1'b0;
            m_done[d] = 1'b1;
         end
      end else if (ld_v[d]) begin
         m_act[d]  = 1'b1;
         m_t[d]    = 0;
         m_word[d] = bb_v[d];
         for (int b = 0; b < 3; b++) begin
            if (d == 0) q0.push_back(bb_v[d][8*b +: 8]);
            else        q1.push_back(bb_v[d][8*b +: 8]);
         end
      end
   endtask

   task automatic mon_step(input int d);
      int c, h, cp;
      logic [7:0] want;
      cp = cpb_of(d);
      h  = cp / 2;
      if (mon_on[d]) begin
         if (!busy_v[d]) begin
            mon_on[d] = 1'b0;
         end else begin
            mon_c[d]++;
            c = mon_c[d];
            if (c >= cp + h && c < 9*cp && ((c - h) % cp) == 0) begin
               mon_b[d][(c - h)/cp - 1] = tx_v[d];
            end else if (c == 9*cp + h) begin
               check_val($sformatf("stop%0d", d), {31'd0, tx_v[d]}, 32'd1);
               if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                  check_val($sformatf("extra_byte%0d", d), 32'd1, 32'd0);
               end else begin
                  want = (d == 0) ? q0.pop_front() : q1.pop_front();
                  check_val($sformatf("byte%0d", d), {24'd0, mon_b[d]}, {24'd0, want});
               end
               n_bytes[d]++;
               mon_on[d] = 1'b0;
            end
         end
      end else if (tx_v[d] == 1'b0 && busy_v[d] == 1'b1) begin
         mon_on[d] = 1'b1;
         mon_c[d]  = 0;
      end
   endtask

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) model_edge(d);
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int d = 0; d < 2; d++) begin
            check_val($sformatf("tx%0d", d),   {31'd0, tx_v[d]},   {31'd0, exp_tx(d)});
            check_val($sformatf("busy%0d", d), {31'd0, busy_v[d]}, {31'd0, m_act[d]});
            check_val($sformatf("done%0d", d), {31'd0, done_v[d]}, {31'd0, m_done[d]});
            mon_step(d);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive(input int d, input logic ld, input logic [23:0] w);
      if (d == 0) begin
         if0.load  = ld;
         if0.B_bus = w;
      end else begin
         if1.load  = ld;
         if1.B_bus = w;
      end
   endtask

   task automatic set_rst(input int d, input logic r);
      if (d == 0) rst0 = r; else rst1 = r;
   endtask

   task automatic load_word(input int d, input logic [23:0] w);
      drive(d, 1'b1, w);
      tick(1);
      drive(d, 1'b0, 24'($urandom));
   endtask

   // Waits for done on instance d, counting busy cycles on the way
   task automatic wait_done(input int d, input int budget, output int busy_cnt);
      int n;
      bit seen;
      busy_cnt = 0;
      seen     = 1'b0;
      n        = 0;
      while (!seen && n < budget) begin
         @(negedge clk);
         if (busy_v[d]) busy_cnt++;
         if (done_v[d]) seen = 1'b1;
         n++;
      end
      if (!seen) check_val($sformatf("timeout%0d", d), 32'd0, 32'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int bc;
      int d;
      int r;
      rst0 = 1'b1;
      rst1 = 1'b1;
      drive(0, 1'b0, 24'd0);
      drive(1, 1'b0, 24'd0);
      tick(2);
      chk_en = 1'b1;
      set_rst(0, 1'b0);
      set_rst(1, 1'b0);
      tick(3);

      // Basic word
      load_word(0, 24'hA53C0F);
      wait_done(0, 40*CPB0, bc);
      check_val("busy_len_basic", bc, 30*CPB0);
      tick(5);

      // Reset held with load high: nothing may start
      set_rst(0, 1'b1);
      drive(0, 1'b1, 24'hFFFFFF);
      tick(5);
      set_rst(0, 1'b0);
      drive(0, 1'b0, 24'hFFFFFF);
      tick(50);

      // Loads while busy are ignored
      load_word(0, 24'h000001);
      tick(100);
      for (int i = 0; i < 20; i++) begin
         drive(0, 1'b1, 24'($urandom));
         tick(1);
      end
      drive(0, 1'b0, 24'hFFFFFF);
      wait_done(0, 40*CPB0, bc);
      tick(40*CPB0);

      // Back-to-back words, second load the cycle after done
      load_word(0, 24'h123456);
      wait_done(0, 40*CPB0, bc);
      check_val("busy_len_b2b", bc, 30*CPB0);
      load_word(0, 24'h654321);
      wait_done(0, 40*CPB0, bc);
      check_val("busy_len_b2b2", bc, 30*CPB0);
      tick(5);

      // Reset during the second byte's data bits
      load_word(0, 24'hAAAAAA);
      tick(10*CPB0 + CPB0 + 3*CPB0);
      set_rst(0, 1'b1);
      tick(1);
      set_rst(0, 1'b0);
      tick(5);
      load_word(0, 24'h000055);
      wait_done(0, 40*CPB0, bc);
      check_val("busy_len_after_rst", bc, 30*CPB0);

      // Minimum divisor
      load_word(1, 24'h800001);
      wait_done(1, 40*CPB1, bc);
      check_val("busy_len_min", bc, 30*CPB1);
      tick(5);

      // Randomized loads, overlapping loads and resets on both instances
      for (int i = 0; i < 60; i++) begin
         d = $urandom_range(0, 1);
         r = $urandom_range(0, 9);
         if (r == 0) begin
            tick($urandom_range(0, 20*cpb_of(d)));
            set_rst(d, 1'b1);
            tick($urandom_range(1, 2));
            set_rst(d, 1'b0);
         end else begin
            load_word(d, 24'($urandom));
         end
         tick($urandom_range(0, 32*cpb_of(d)));
      end

      tick(40*CPB0);
      check_val("queue0_empty", q0.size(), 32'd0);
      check_val("queue1_empty", q1.size(), 32'd0);
      check_val("bytes0_seen", {31'd0, (n_bytes[0] >= 15)}, 32'd1);
      check_val("bytes1_seen", {31'd0, (n_bytes[1] >= 3)}, 32'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
